stream_mux: RTL and testbench
=============================

STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 Parameter NUM_CH, default 4: number of input channels, legal range 2..16.
REQ-002 Parameter DATA_W, default 8: data width per channel, legal minimum 1.
REQ-003 Derived width CH_W = max(1, clog2(NUM_CH)).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 in_valid  input  NUM_CH  per-channel valid; bit k belongs to channel k.
REQ-007 in_data  input  NUM_CH*DATA_W  flattened data; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-008 in_last  input  NUM_CH  per-channel end-of-packet flag.
REQ-009 in_ready  output  NUM_CH  per-channel ready; at most one bit high per cycle.
REQ-010 sel  input  CH_W  channel select; used only in fixed-select mode (REQ-031).
REQ-011 out_valid  output  1  registered output valid.
REQ-012 out_data  output  DATA_W  registered output data.
REQ-013 out_last  output  1  registered end-of-packet flag.
REQ-014 out_ch  output  CH_W  index of the source channel of the current output word.
REQ-015 out_ready  input  1  downstream ready.

Function
REQ-016 Grant is a single channel index g, computed combinationally from the current state, in_valid and sel.
REQ-017 in_ready[g] = !out_valid || out_ready; all other in_ready bits are 0.
REQ-018 Input transfer occurs when in_valid[g] && in_ready[g]; on that edge out_data/out_last/out_ch load channel g's data, last flag and index, and out_valid becomes 1.
REQ-019 Latency is exactly one cycle from input transfer to out_valid; throughput is one word per cycle while out_ready=1.
REQ-020 Output transfer occurs when out_valid && out_ready; without a simultaneous input transfer, out_valid goes to 0 on that edge.
REQ-021 A simultaneous output transfer and input transfer replaces the output register with no bubble.
REQ-022 While out_valid=1 and out_ready=0, out_data/out_last/out_ch hold stable.
REQ-023 The state machine has two states: ARB and LOCK; the lock channel register is lk.
REQ-024 ARB: g comes from the arbitration mode; an input transfer with in_last=0 moves to LOCK and sets lk=g; an input transfer with in_last=1 stays in ARB.
REQ-025 LOCK: g=lk regardless of other valids or sel; an input transfer with in_last=1 returns to ARB; otherwise stay in LOCK.
REQ-026 Packets from different channels never interleave at the output.
REQ-027 When no channel qualifies for grant, all in_ready bits are 0.

Reset
REQ-028 While rst_n=0 at a rising edge, the block sets out_valid=0, out_data=0, out_last=0, out_ch=0, state=ARB, lk=0, and the round-robin pointer to NUM_CH-1.
REQ-029 in_ready is all-zero in any cycle where rst_n=0.
REQ-030 Reset asserted mid-packet abandons the lock; the first grant after reset follows ARB rules.

Configuration
REQ-031 Without STREAM_MUX_RR_EN (fixed-select mode), ARB grant is g=sel; if sel>=NUM_CH, nothing is granted.
REQ-032 With STREAM_MUX_RR_EN, sel is ignored and ARB grant is the first channel with in_valid=1, searching from pointer+1 upward and wrapping modulo NUM_CH.
REQ-033 In round-robin mode the pointer updates to g on every input transfer with in_last=1, and holds otherwise.
REQ-034 In round-robin mode, a channel with in_valid=1 receives a grant within NUM_CH packet completions.

Verification
REQ-035 Reset, then check outputs: out_valid=0, out_ch=0, in_ready=0000, and the first post-reset grant follows ARB rules.
REQ-036 Fixed mode, NUM_CH=4: sel=2, in_valid=0100, in_data ch2=0xA5, in_last=1, out_ready=1 -> out_valid=1 next cycle, out_data=0xA5, out_ch=2.
REQ-037 Backpressure: out_ready=0 with out_valid=1 -> in_ready=0000, outputs hold; raise out_ready -> same-cycle input accept and no bubble.
REQ-038 Lock: ch1 sends 3-word packet 0x11,0x12,0x13 (last on third) while ch0 is valid and sel moves to 0 mid-packet -> output ch1 words contiguous, then ch0.
REQ-039 RR mode: all four channels valid with single-word packets -> out_ch sequence 0,1,2,3,0.
REQ-040 Reset asserted while in LOCK on ch3, released with ch0 and ch3 valid -> RR mode grants ch0 first; fixed mode grants the sel channel.

Source files
------------

// File: rtl/stream_mux.sv
// stream_mux: N-to-1 packet-aware stream mux; optional round-robin arbitration with STREAM_MUX_RR_EN.
// Latency: one cycle from input transfer to out_valid; sustains one word per cycle.
// Backpressure: only the granted channel sees in_ready, and only while the output register can accept.
module stream_mux #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_last,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [CH_W-1:0]          sel,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [CH_W-1:0]          out_ch,
    input  logic                     out_ready
);

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [CH_W-1:0]   lk_q, lk_d;
    logic              out_vld_q, out_vld_d;
    logic [DATA_W-1:0] out_dat_q, out_dat_d;
    logic              out_last_q, out_last_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;

    logic [CH_W-1:0]   arb_g;
    logic              arb_vld;
    logic [CH_W-1:0]   grant;
    logic              grant_vld;
    logic              acc_ok;
    logic [DATA_W-1:0] g_dat;
    logic              g_last;
    logic              g_valid;
    logic              in_xfer;
    logic              out_xfer;

`ifdef STREAM_MUX_RR_EN
    logic [CH_W-1:0] ptr_q, ptr_d;
    int              dist;
    int              best;
    logic            unused_sel;

    assign unused_sel = ^sel;

    // Pick the valid channel closest after the pointer, wrapping around.
    always_comb begin
        arb_vld = 1'b0;
        arb_g   = '0;
        best    = NUM_CH;
        dist    = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            dist = k - int'(ptr_q) - 1;
            if (dist < 0) begin
                dist = dist + NUM_CH;
            end
            if (in_valid[k] && (dist < best)) begin
                best    = dist;
                arb_g   = CH_W'(k);
                arb_vld = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (in_xfer && g_last) begin
            ptr_d = grant;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= CH_W'(NUM_CH - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        arb_g   = sel;
        arb_vld = (int'(sel) < NUM_CH);
    end
`endif

    // An open packet pins the grant to its channel, so packets never interleave.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        if (rst_n) begin
            if (state_q == ST_LOCK) begin
                grant_vld = 1'b1;
                grant     = lk_q;
            end else begin
                grant_vld = arb_vld;
                grant     = arb_g;
            end
        end
    end

    assign acc_ok = !out_vld_q || out_ready;

    always_comb begin
        in_ready = '0;
        g_dat    = '0;
        g_last   = 1'b0;
        g_valid  = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant == CH_W'(k)) begin
                in_ready[k] = grant_vld && acc_ok;
                g_dat       = in_data[k*DATA_W +: DATA_W];
                g_last      = in_last[k];
                g_valid     = in_valid[k];
            end
        end
    end

    assign in_xfer  = grant_vld && acc_ok && g_valid;
    assign out_xfer = out_vld_q && out_ready;

    always_comb begin
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        out_last_d = out_last_q;
        out_ch_d   = out_ch_q;
        state_d    = state_q;
        lk_d       = lk_q;
        if (in_xfer) begin
            out_vld_d  = 1'b1;
            out_dat_d  = g_dat;
            out_last_d = g_last;
            out_ch_d   = grant;
            if (state_q == ST_ARB) begin
                if (!g_last) begin
                    state_d = ST_LOCK;
                    lk_d    = grant;
                end
            end else if (g_last) begin
                state_d = ST_ARB;
            end
        end else if (out_xfer) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            out_last_q <= 1'b0;
            out_ch_q   <= '0;
            state_q    <= ST_ARB;
            lk_q       <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            out_last_q <= out_last_d;
            out_ch_q   <= out_ch_d;
            state_q    <= state_d;
            lk_q       <= lk_d;
        end
    end

    assign out_valid = out_vld_q;
    assign out_data  = out_dat_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux.sv
// Randomized and directed bench for stream_mux against a packet-level reference model.
module tb_stream_mux;
    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int CH_W   = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_last;
    logic [NUM_CH-1:0]        in_ready;
    logic [CH_W-1:0]          sel;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic                     out_last;
    logic [CH_W-1:0]          out_ch;
    logic                     out_ready;

    int total;
    int bad;
    bit started;

    stream_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Reference model: output register contents, open-packet channel, rr pointer.
    bit                m_vld;
    logic [DATA_W-1:0] m_dat;
    bit                m_last;
    int                m_ch;
    bit                m_lock;
    int                m_lk;
    int                m_ptr;

    // Granted channel index, or -1 if no channel may be granted.
    function automatic int mg();
        int g;
        g = -1;
        if (!rst_n) return -1;
        if (m_lock) return m_lk;
`ifdef STREAM_MUX_RR_EN
        for (int i = 1; i <= NUM_CH; i++) begin
            int c;
            c = (m_ptr + i) % NUM_CH;
            if (g < 0 && bit'(in_valid >> c)) g = c;
        end
`else
        if (int'(sel) < NUM_CH) g = int'(sel);
`endif
        return g;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_ready();
        int g;
        g = mg();
        if (g < 0 || !(!m_vld || out_ready)) return '0;
        return NUM_CH'(1) << g;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_vld  <= 1'b0;
            m_dat  <= '0;
            m_last <= 1'b0;
            m_ch   <= 0;
            m_lock <= 1'b0;
            m_lk   <= 0;
            m_ptr  <= NUM_CH - 1;
        end else if (mg() >= 0 && bit'(in_valid >> mg()) && (!m_vld || out_ready)) begin
            m_vld  <= 1'b1;
            m_dat  <= DATA_W'(in_data >> (mg() * DATA_W));
            m_last <= bit'(in_last >> mg());
            m_ch   <= mg();
            if (bit'(in_last >> mg())) begin
                m_lock <= 1'b0;
                m_ptr  <= mg();
            end else begin
                m_lock <= 1'b1;
                m_lk   <= mg();
            end
        end else if (m_vld && out_ready) begin
            m_vld <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("in_ready",  32'(in_ready),  32'(exp_ready()));
        chk("out_valid", 32'(out_valid), 32'(m_vld));
        chk("out_data",  32'(out_data),  32'(m_dat));
        chk("out_last",  32'(out_last),  32'(m_last));
        chk("out_ch",    32'(out_ch),    32'(m_ch));
    endtask

    task automatic step();
        @(negedge clk);
        if (started) compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [DATA_W-1:0] d, input logic l);
        in_data[k*DATA_W +: DATA_W] = d;
        in_last[k] = l;
    endtask

    initial begin
        total = 0;
        bad = 0;
        started = 1'b0;
        rst_n = 1'b0;
        in_valid = '0;
        in_data = '0;
        in_last = '0;
        sel = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        started = 1'b1;
        step();

        // Reset state
        in_valid = '1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_ch", 32'(out_ch), 32'h0);
        step();
        rst_n = 1'b1;
        in_valid = '0;
        sel = 2'd2;
        step();

        // Single word from channel 2
        in_valid = 4'b0100;
        set_ch(2, 8'hA5, 1'b1);
        out_ready = 1'b1;
        step();
        chk("single_valid", 32'(out_valid), 32'h1);
        chk("single_data", 32'(out_data), 32'hA5);
        chk("single_ch", 32'(out_ch), 32'h2);
        chk("model_single_data", 32'(m_dat), 32'hA5);

        // Backpressure then release with no bubble
        out_ready = 1'b0;
        set_ch(2, 8'h5A, 1'b1);
        #1;
        chk("bp_in_ready", 32'(in_ready), 32'h0);
        step();
        chk("bp_hold_valid", 32'(out_valid), 32'h1);
        chk("bp_hold_data", 32'(out_data), 32'hA5);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'h4);
        step();
        chk("nobubble_valid", 32'(out_valid), 32'h1);
        chk("nobubble_data", 32'(out_data), 32'h5A);
        in_valid = '0;
        step();
        chk("drain_valid", 32'(out_valid), 32'h0);

        // Lock: ch1 packet stays contiguous while sel moves and ch0 waits
        sel = 2'd1;
        in_valid = 4'b0010;
        set_ch(1, 8'h11, 1'b0);
        set_ch(0, 8'h77, 1'b1);
        step();
        chk("lock_w1_data", 32'(out_data), 32'h11);
        chk("lock_w1_ch", 32'(out_ch), 32'h1);
        sel = 2'd0;
        in_valid = 4'b0011;
        set_ch(1, 8'h12, 1'b0);
        step();
        chk("lock_w2_data", 32'(out_data), 32'h12);
        chk("lock_w2_ch", 32'(out_ch), 32'h1);
        set_ch(1, 8'h13, 1'b1);
        step();
        chk("lock_w3_data", 32'(out_data), 32'h13);
        chk("lock_w3_ch", 32'(out_ch), 32'h1);
        in_valid = 4'b0001;
        step();
        chk("lock_next_data", 32'(out_data), 32'h77);
        chk("lock_next_ch", 32'(out_ch), 32'h0);
        in_valid = '0;
        step();

        // Grant order with all channels offering single-word packets
        for (int k = 0; k < NUM_CH; k++) set_ch(k, DATA_W'(8'h30 + k), 1'b1);
`ifdef STREAM_MUX_RR_EN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        in_valid = '1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rr_seq_ch", 32'(out_ch), 32'(i % NUM_CH));
        end
`else
        in_valid = '1;
        for (int i = 0; i < NUM_CH; i++) begin
            sel = CH_W'(i);
            step();
            chk("fixed_seq_ch", 32'(out_ch), 32'(i));
            chk("fixed_seq_data", 32'(out_data), 32'(8'h30 + i));
        end
`endif
        in_valid = '0;
        step();

        // Reset while locked on ch3 abandons the lock
        sel = 2'd3;
        in_valid = 4'b1000;
        set_ch(3, 8'hC3, 1'b0);
        step();
        chk("lock3_ch", 32'(out_ch), 32'h3);
        chk("model_lock3", 32'(m_lock), 32'h1);
        rst_n = 1'b0;
        in_valid = 4'b1001;
        #1;
        chk("rst_lock_ready", 32'(in_ready), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        sel = 2'd0;
        set_ch(0, 8'hC0, 1'b1);
        set_ch(3, 8'hC4, 1'b1);
        step();
        chk("post_rst_ch", 32'(out_ch), 32'h0);
        chk("post_rst_data", 32'(out_data), 32'hC0);
        in_valid = '0;
        step();

        // Randomized traffic checked every cycle against the model
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            in_valid = NUM_CH'($urandom);
            in_data = (NUM_CH*DATA_W)'($urandom);
            for (int k = 0; k < NUM_CH; k++) in_last[k] = ($urandom_range(0, 2) == 0);
            sel = CH_W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
